branch_predict_unit: RTL and testbench

//  Parametrised successor to the ID-stage branch-resolve logic.
//  - Keeps the same resolve rule: DE_control[1] = is-branch; DE_control[0] = 1 for beq, 0 for bne.
//  - Adds a PC-indexed table of 2-bit saturating counters, read in IF to predict taken/not-taken.
//  - Resolves the branch in ID, flags a misprediction and trains the table.
//  - Keeps saturating branch/mispredict statistics counters.

---
 rtl/branch_predict_unit.sv | 79 +++++++
 tb/tb_branch_predict_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// PC-indexed 2-bit saturating-counter branch predictor with ID-stage resolve, training and stats.
// Prediction and resolution are combinational (zero latency); table and stats update on the next edge; no backpressure (de_stall suppresses resolve).
module branch_predict_unit #(
  parameter int         ADDR_W   = 32,
  parameter int         IDX_W    = 6,
  parameter logic [1:0] CTR_INIT = 2'b01,
  parameter int         CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  input  logic              de_valid,
  input  logic              de_stall,
  input  logic [ADDR_W-1:0] de_pc,
  input  logic [1:0]        DE_control,
  input  logic              cmp,
  input  logic              de_pred_taken,
  output logic              PC_sel,
  output logic              mispredict,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam int DEPTH = 1 << IDX_W;

  if (IDX_W + 2 > ADDR_W) begin : g_bad_idx_w
    $error("branch_predict_unit: IDX_W+2 must not exceed ADDR_W");
  end

  logic [1:0]       ctr [DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] de_idx;
  logic             rv;
  logic             train;
  logic             unused_pc_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign de_idx = de_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{if_pc, de_pc};

  // Read is from the registered table only: a same-cycle training write is not bypassed.
  assign pred_taken = if_valid & ctr[if_idx][1];

  assign rv         = de_valid & ~de_stall;
  assign PC_sel     = rv & DE_control[1] & (DE_control[0] ~^ cmp);
  assign mispredict = rv & (PC_sel != de_pred_taken);
  assign train      = rv & DE_control[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr[i] <= CTR_INIT;
      end
    end else if (train) begin
      if (PC_sel && ctr[de_idx] != 2'b11) begin
        ctr[de_idx] <= ctr[de_idx] + 2'd1;
      end else if (!PC_sel && ctr[de_idx] != 2'b00) begin
        ctr[de_idx] <= ctr[de_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (train && branch_cnt != {CNT_W{1'b1}}) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (mispredict && mispred_cnt != {CNT_W{1'b1}}) begin
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: default instance plus a CNT_W=2 instance sharing all inputs.
module tb_branch_predict_unit;

  logic        clk;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        de_valid;
  logic        de_stall;
  logic [31:0] de_pc;
  logic [1:0]  DE_control;
  logic        cmp;
  logic        de_pred_taken;
  logic        PC_sel;
  logic        mispredict;
  logic [15:0] branch_cnt;
  logic [15:0] mispred_cnt;
  logic        pred_taken2;
  logic        pc_sel2;
  logic        mispredict2;
  logic [1:0]  branch_cnt2;
  logic [1:0]  mispred_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  branch_predict_unit dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .pred_taken(pred_taken),
    .de_valid(de_valid), .de_stall(de_stall), .de_pc(de_pc), .DE_control(DE_control),
    .cmp(cmp), .de_pred_taken(de_pred_taken), .PC_sel(PC_sel), .mispredict(mispredict),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_predict_unit #(.CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .pred_taken(pred_taken2),
    .de_valid(de_valid), .de_stall(de_stall), .de_pc(de_pc), .DE_control(DE_control),
    .cmp(cmp), .de_pred_taken(de_pred_taken), .PC_sel(pc_sel2), .mispredict(mispredict2),
    .branch_cnt(branch_cnt2), .mispred_cnt(mispred_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_de(input logic v, input logic [31:0] pc, input logic [1:0] ctl,
                          input logic c, input logic p);
    de_valid      = v;
    de_pc         = pc;
    DE_control    = ctl;
    cmp           = c;
    de_pred_taken = p;
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    if_valid = 1'b1;
    if_pc    = 32'h40;
    de_stall = 1'b0;
    drive_de(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);

    // 1: reset state; resolve outputs still follow inputs while reset is high
    chk("rst_pred", pred_taken, 0);
    step(2);
    chk("rst_branch_cnt", branch_cnt, 0);
    chk("rst_mispred_cnt", mispred_cnt, 0);
    drive_de(1'b1, 32'h40, 2'b11, 1'b1, 1'b0);
    chk("rst_pc_sel_follows", PC_sel, 1);
    chk("rst_mispred_follows", mispredict, 1);
    step(1);
    chk("rst_no_train", pred_taken, 0);
    chk("rst_no_count", branch_cnt, 0);
    drive_de(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    reset = 1'b0;

    // 2: taken beq at 0x40 predicted not-taken, twice
    drive_de(1'b1, 32'h40, 2'b11, 1'b1, 1'b0);
    chk("t2_pc_sel_a", PC_sel, 1);
    chk("t2_mispred_a", mispredict, 1);
    step(1);
    chk("t2_pc_sel_b", PC_sel, 1);
    chk("t2_mispred_b", mispredict, 1);
    step(1);
    drive_de(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    chk("t2_pred", pred_taken, 1);
    chk("t2_mispred_cnt", mispred_cnt, 2);
    chk("t2_branch_cnt", branch_cnt, 2);

    // 3: saturation at 0x80
    if_pc = 32'h80;
    drive_de(1'b1, 32'h80, 2'b11, 1'b1, 1'b1);
    chk("t3_no_mispred", mispredict, 0);
    step(5);
    drive_de(1'b1, 32'h80, 2'b11, 1'b0, 1'b1);
    chk("t3_nt_mispred", mispredict, 1);
    step(1);
    chk("t3_pred_after_one_nt", pred_taken, 1);
    step(2);
    drive_de(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    chk("t3_pred_after_three_nt", pred_taken, 0);
    chk("t3_branch_cnt", branch_cnt, 10);
    chk("t3_mispred_cnt", mispred_cnt, 5);
    chk("t3_small_branch_sat", branch_cnt2, 3);

    // 4: bne
    drive_de(1'b1, 32'hC0, 2'b10, 1'b0, 1'b1);
    chk("t4_bne_taken", PC_sel, 1);
    chk("t4_bne_no_mispred", mispredict, 0);
    step(1);
    drive_de(1'b1, 32'hC0, 2'b10, 1'b1, 1'b1);
    chk("t4_bne_not_taken", PC_sel, 0);
    chk("t4_bne_mispred", mispredict, 1);
    step(1);
    drive_de(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    chk("t4_branch_cnt", branch_cnt, 12);
    chk("t4_mispred_cnt", mispred_cnt, 6);

    // 5: read/write collision, non-branch, stall, X-safety
    if_pc = 32'h100;
    drive_de(1'b1, 32'h100, 2'b11, 1'b1, 1'b0);
    chk("t5_coll_old_value", pred_taken, 0);
    step(1);
    drive_de(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    chk("t5_coll_new_value", pred_taken, 1);
    drive_de(1'b1, 32'h100, 2'b00, 1'b0, 1'b1);
    chk("t5_nonbr_pc_sel", PC_sel, 0);
    chk("t5_nonbr_mispred", mispredict, 1);
    step(1);
    de_stall = 1'b1;
    drive_de(1'b1, 32'h100, 2'b11, 1'b0, 1'b1);
    chk("t5_stall_pc_sel", PC_sel, 0);
    chk("t5_stall_mispred", mispredict, 0);
    step(1);
    de_stall = 1'b0;
    drive_de(1'b0, 32'h100, 2'b11, 1'b1, 1'b0);
    chk("t5_table_unchanged", pred_taken, 1);
    chk("t5_branch_cnt", branch_cnt, 13);
    chk("t5_mispred_cnt", mispred_cnt, 8);
    chk("t5_invalid_pc_sel", PC_sel, 0);
    chk("t5_invalid_mispred", mispredict, 0);
    if_valid = 1'b0;
    #1;
    chk("t5_if_invalid_pred", pred_taken, 0);
    if_valid = 1'b1;

    // 6: reset during training at 0x40 (counter 11), then CNT_W=2 saturation
    if_pc = 32'h40;
    drive_de(1'b1, 32'h40, 2'b11, 1'b0, 1'b1);
    chk("t6_pre_reset_pred", pred_taken, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_reset_pred", pred_taken, 0);
    chk("t6_reset_branch_cnt", branch_cnt, 0);
    step(1);
    drive_de(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("t6_ctr_init", pred_taken, 0);
    chk("t6_mispred_cnt", mispred_cnt, 0);
    drive_de(1'b1, 32'h40, 2'b11, 1'b1, 1'b0);
    step(1);
    chk("t6_first_edge_train", pred_taken, 1);
    drive_de(1'b1, 32'h180, 2'b11, 1'b1, 1'b0);
    step(3);
    drive_de(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    chk("t6_branch_cnt", branch_cnt, 4);
    chk("t6_mispred_cnt_4", mispred_cnt, 4);
    chk("t6_small_branch_cnt", branch_cnt2, 3);
    chk("t6_small_mispred_cnt", mispred_cnt2, 3);
    chk("t6_small_pred", pred_taken2, 1);
    chk("t6_small_pc_sel", pc_sel2, 0);
    chk("t6_small_mispred", mispredict2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
